conv_systolic_param: RTL
========================

CONV_SYSTOLIC_PARAM -- requirements
Module: conv_systolic_param

Interface
REQ-001 Parameter DW, 8, pixel/weight/result width (unsigned).
REQ-002 Parameter N, 4, input image side (N x N).
REQ-003 Parameter K, 3, filter side (K x K); K <= N.
REQ-004 Parameter P, 1, parallel MAC lanes; 1 <= P <= M, where M = (N-K+1)^2.
REQ-005 Parameter SAT, 0, output mode: 0 = wrap (low DW bits), 1 = saturate to 2^DW-1.
REQ-006 Derived: OW = N-K+1; ACCW = 2*DW + clog2(K*K).
REQ-007 Design SHALL use one clock; reset is synchronous and active-low.
REQ-008 clk  in  1  sole clock; all state updates on rising edge.
REQ-009 rst  in  1  synchronous active-low reset.
REQ-010 start  in  1  begin job; sampled only in IDLE.
REQ-011 busy  out  1  high whenever state != IDLE.
REQ-012 done  out  1  one-cycle pulse on job completion.
REQ-013 in_valid / in_ready / in_data  in / out / in  1 / 1 / DW  load stream: K*K weights then N*N pixels, row-major.
REQ-014 out_valid / out_ready / out_data  out / in / out  1 / 1 / DW  result stream, OW*OW words, row-major.

Function
REQ-015 FSM states IDLE, LOAD, COMP, OUT; IDLE->LOAD on start=1; LOAD->COMP after word K*K+N*N accepted; COMP->OUT after final MAC cycle; OUT->IDLE after last output handshake.
REQ-016 in_ready SHALL be 1 only in LOAD; transfer occurs when in_valid & in_ready; in_valid outside LOAD ignored.
REQ-017 Load words 0..K*K-1 SHALL fill filter f[r][c]; words K*K.. fill image i[r][c], row-major.
REQ-018 start asserted while busy SHALL be ignored.
REQ-019 Output o[y][x] = sum over r,c<K of i[y+r][x+c]*f[r][c], computed in ACCW-bit unsigned accumulator without overflow.
REQ-020 Lane p computes outputs with row-major index j where j mod P = p; each output takes K*K cycles (one product per lane per cycle).
REQ-021 COMP SHALL last exactly ceil(M/P)*K*K cycles; lanes with no remaining output idle.
REQ-022 SAT=0: out_data = acc[DW-1:0]; SAT=1: out_data = 2^DW-1 if acc > 2^DW-1, else acc.
REQ-023 In OUT, out_valid=1 and out_data SHALL hold stable until out_ready=1; index advances once per handshake; out_ready outside OUT ignored.
REQ-024 done SHALL pulse in the cycle state returns to IDLE; busy drops the same cycle.
REQ-025 Back-to-back job: start in the cycle after done SHALL be accepted; filter and image reloaded fully each job.

Reset
REQ-026 rst=0 at a rising edge SHALL force IDLE from any state, discarding partial load, accumulators and results.
REQ-027 Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, all counters 0.
REQ-028 After rst returns to 1, block SHALL accept start on the first edge.

Verification
REQ-029 Defaults, weights {181,176,207,111,248,115,64,95,253}, image {252,165,199,27,93,28,86,176,149,110,113,249,234,207,29,30}, in_valid always 1, out_ready always 1 -> outputs 89,86,115,106 in order; COMP = 36 cycles.
REQ-030 Same data, SAT=1 -> outputs 255,255,255,255 (sums 191577,195926,138355,149098).
REQ-031 Same data, P=2 -> identical outputs 89,86,115,106; COMP = 18 cycles.
REQ-032 Same data, in_valid toggling every other cycle and out_ready low 3 cycles before each output -> same 4 results, out_data stable while stalled, no duplicates or drops.
REQ-033 rst=0 mid-COMP, then new job with all weights 1 and all pixels 1 -> outputs 9,9,9,9; no stale data.
REQ-034 start pulsed during LOAD and OUT -> ignored; exactly one done pulse per job.

Source files
------------

// File: rtl/conv_systolic_param.sv
// conv_systolic_param: K x K valid-mode convolution over an N x N image with P parallel MAC lanes.
// Load stream fills filter then image; results stream out row-major after the MAC phase.
module conv_systolic_param #(
    parameter int DW  = 8,
    parameter int N   = 4,
    parameter int K   = 3,
    parameter int P   = 1,
    parameter int SAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    localparam int OW   = N - K + 1;
    localparam int M    = OW * OW;
    localparam int KK   = K * K;
    localparam int NN   = N * N;
    localparam int L    = KK + NN;
    localparam int ACCW = 2 * DW + $clog2(KK);
    localparam int G    = (M + P - 1) / P;
    localparam int LW   = $clog2(L);
    localparam int TW   = KK > 1 ? $clog2(KK) : 1;
    localparam int IW   = NN > 1 ? $clog2(NN) : 1;
    localparam int GW   = G > 1 ? $clog2(G) : 1;
    localparam int MW   = M > 1 ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMP, OUT} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     ld_q, ld_d;
    logic [TW-1:0]     t_q, t_d;
    logic [GW-1:0]     g_q, g_d;
    logic [MW-1:0]     oi_q, oi_d;
    logic              done_q, done_d;
    logic [DW-1:0]     f_q [KK];
    logic [DW-1:0]     img_q [NN];
    logic [ACCW-1:0]   acc_q [M];
    logic [ACCW-1:0]   acc_d [M];
    logic [ACCW-1:0]   res;

    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign in_ready  = state_q == LOAD;
    assign out_valid = state_q == OUT;
    assign res       = acc_q[oi_q];
    assign out_data  = !out_valid ? '0 :
                       (SAT != 0 && res > ACCW'({DW{1'b1}})) ? {DW{1'b1}} : res[DW-1:0];

    // Product of tap t for output j: pixel (y+r, x+c) times weight (r, c).
    function automatic logic [ACCW-1:0] prod(input int j, input int t);
        int pix;
        pix = (j / OW + t / K) * N + j % OW + t % K;
        return ACCW'(img_q[IW'(pix)]) * ACCW'(f_q[TW'(t)]);
    endfunction

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        t_d     = t_q;
        g_d     = g_q;
        oi_d    = oi_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: state_d = start ? LOAD : IDLE;
            LOAD: if (in_valid) begin
                ld_d    = (ld_q == LW'(L - 1)) ? '0 : ld_q + 1'b1;
                state_d = (ld_q == LW'(L - 1)) ? COMP : LOAD;
            end
            COMP: begin
                t_d = (t_q == TW'(KK - 1)) ? '0 : t_q + 1'b1;
                if (t_q == TW'(KK - 1)) begin
                    g_d     = (g_q == GW'(G - 1)) ? '0 : g_q + 1'b1;
                    state_d = (g_q == GW'(G - 1)) ? OUT : COMP;
                end
            end
            OUT: if (out_ready) begin
                oi_d    = (oi_q == MW'(M - 1)) ? '0 : oi_q + 1'b1;
                state_d = (oi_q == MW'(M - 1)) ? IDLE : OUT;
                done_d  = oi_q == MW'(M - 1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Tap 0 overwrites the accumulator, so no separate clear is needed between jobs.
    always_comb begin
        acc_d = acc_q;
        for (int p = 0; p < P; p++)
            if (state_q == COMP && int'(g_q) * P + p < M)
                acc_d[MW'(int'(g_q) * P + p)] =
                    (t_q == '0 ? '0 : acc_q[MW'(int'(g_q) * P + p)]) + prod(int'(g_q) * P + p, int'(t_q));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ld_q    <= '0;
            t_q     <= '0;
            g_q     <= '0;
            oi_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            t_q     <= t_d;
            g_q     <= g_d;
            oi_q    <= oi_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD && in_valid) begin
            if (ld_q < LW'(KK))
                f_q[TW'(ld_q)] <= in_data;
            else
                img_q[IW'(ld_q - LW'(KK))] <= in_data;
        end
        acc_q <= acc_d;
    end
endmodule
